// File: rtl/scmp_bus_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scmp_bus_ctl_if                                              |
// | Description : Bundles the microcode-side request/ack handshake and the     |
// |               external bus pins of scmp_bus_ctl.                           |
// |               master modport : the bus controller itself                   |
// |               slave  modport : sequencer + memory/arbiter environment      |
// |               Signals: mc_req/mc_wr/mc_addr/mc_wdata -> controller,        |
// |               mc_ack/mc_rdata/busy <- controller, enin/hold/bus_din ->     |
// |               controller, breq/enout/bus_addr/bus_dout/bus_doe/            |
// |               bus_ADS_n/bus_RD_n/bus_WR_n <- controller.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface scmp_bus_ctl_if #(
   parameter int ADDR_W = 16
);
   // microcode sequencer side
   logic              mc_req;
   logic              mc_wr;
   logic [ADDR_W-1:0] mc_addr;
   logic [7:0]        mc_wdata;
   logic              mc_ack;
   logic [7:0]        mc_rdata;
   logic              busy;
   // arbitration daisy chain
   logic              enin;
   logic              breq;
   logic              enout;
   // external bus
   logic              hold;
   logic [ADDR_W-1:0] bus_addr;
   logic [7:0]        bus_din;
   logic [7:0]        bus_dout;
   logic              bus_doe;
   logic              bus_ADS_n;
   logic              bus_RD_n;
   logic              bus_WR_n;

   modport master (
      input  mc_req, mc_wr, mc_addr, mc_wdata, enin, hold, bus_din,
      output mc_ack, mc_rdata, busy, breq, enout,
             bus_addr, bus_dout, bus_doe, bus_ADS_n, bus_RD_n, bus_WR_n
   );

   modport slave (
      output mc_req, mc_wr, mc_addr, mc_wdata, enin, hold, bus_din,
      input  mc_ack, mc_rdata, busy, breq, enout,
             bus_addr, bus_dout, bus_doe, bus_ADS_n, bus_RD_n, bus_WR_n
   );
endinterface
`default_nettype wire

// File: rtl/scmp_bus_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scmp_bus_ctl                                                 |
// | Description : External bus-cycle controller. Accepts one microcode bus     |
// |               request, optionally arbitrates for the bus (enin/breq/enout  |
// |               daisy chain), issues one ADS_n clock, then an RD_n or WR_n   |
// |               strobe of STROBE_CYC clocks (stretched by hold), and returns |
// |               a one-clock mc_ack.                                          |
// |               Ports: clk, rst_n (async, active-low), bus (master modport   |
// |               of scmp_bus_ctl_if).                                         |
// |               Build macro SCMP_BUS_ARB_EN: when defined, the REQ state and |
// |               enin/breq/enout arbitration are present; when undefined the  |
// |               controller owns the bus unconditionally.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module scmp_bus_ctl #(
   parameter int STROBE_CYC = 2,   // 1..15 strobe clocks
   parameter int ADDR_W     = 16
) (
   input logic            clk,
   input logic            rst_n,
   scmp_bus_ctl_if.master bus
);

   localparam logic [3:0] c_strobe_cyc = 4'(STROBE_CYC);

`ifdef SCMP_BUS_ARB_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_ADS  = 3'd2,
      S_STRB = 3'd3,
      S_DONE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADS  = 3'd2,
      S_STRB = 3'd3,
      S_DONE = 3'd4
   } state_t;
`endif

   state_t            r_state;
   logic              r_wr;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_dout;
   logic [7:0]        r_rdata;
   logic              r_ack;
   logic              r_busy;
   logic              r_doe;
   logic              r_ads_n;
   logic              r_rd_n;
   logic              r_wr_n;
`ifdef SCMP_BUS_ARB_EN
   logic              r_breq;
`endif

   // All outputs are decoded one edge early so they are registered and
   // change together with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_dout  <= 8'd0;
         r_rdata <= 8'd0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_doe   <= 1'b0;
         r_ads_n <= 1'b1;
         r_rd_n  <= 1'b1;
         r_wr_n  <= 1'b1;
`ifdef SCMP_BUS_ARB_EN
         r_breq  <= 1'b0;
`endif
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.mc_req) begin
                  r_wr   <= bus.mc_wr;
                  r_addr <= bus.mc_addr;
                  r_dout <= bus.mc_wdata;
                  r_busy <= 1'b1;
`ifdef SCMP_BUS_ARB_EN
                  r_state <= S_REQ;
                  r_breq  <= 1'b1;
`else
                  r_state <= S_ADS;
                  r_ads_n <= 1'b0;
                  r_doe   <= bus.mc_wr;
`endif
               end
            end
`ifdef SCMP_BUS_ARB_EN
            S_REQ: begin
               if (bus.enin) begin
                  r_state <= S_ADS;
                  r_ads_n <= 1'b0;
                  r_doe   <= r_wr;
               end
            end
`endif
            S_ADS: begin
               r_state <= S_STRB;
               r_ads_n <= 1'b1;
               r_cnt   <= 4'd1;
               if (r_wr) begin
                  r_wr_n <= 1'b0;
               end else begin
                  r_rd_n <= 1'b0;
               end
            end
            S_STRB: begin
               if (r_cnt < c_strobe_cyc) begin
                  r_cnt <= r_cnt + 4'd1;
               end else if (!bus.hold) begin
                  // hold only matters on the final counted clock; it keeps
                  // the strobe low until it is sampled low.
                  r_state <= S_DONE;
                  r_rd_n  <= 1'b1;
                  r_wr_n  <= 1'b1;
                  r_ack   <= 1'b1;
                  if (!r_wr) begin
                     r_rdata <= bus.bus_din;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_doe   <= 1'b0;
`ifdef SCMP_BUS_ARB_EN
               r_breq  <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mc_ack    = r_ack;
   assign bus.mc_rdata  = r_rdata;
   assign bus.busy      = r_busy;
   assign bus.bus_addr  = r_addr;
   assign bus.bus_dout  = r_dout;
   assign bus.bus_doe   = r_doe;
   assign bus.bus_ADS_n = r_ads_n;
   assign bus.bus_RD_n  = r_rd_n;
   assign bus.bus_WR_n  = r_wr_n;

`ifdef SCMP_BUS_ARB_EN
   assign bus.breq  = r_breq;
   // Pass the enable down the chain only while idle and not about to claim.
   assign bus.enout = bus.enin & (r_state == S_IDLE) & ~bus.mc_req;
`else
   assign bus.breq  = 1'b0;
   assign bus.enout = bus.enin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_scmp_bus_ctl                                              |
// | Description : Self-checking bench for scmp_bus_ctl. A timeline model      |
// |               derives, for every clock of a transaction, the expected      |
// |               strobes, ack, busy, breq, doe, enout and latched data from   |
// |               the cycle's phase lengths. Follows SCMP_BUS_ARB_EN.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_scmp_bus_ctl;

   localparam int S = 2;
`ifdef SCMP_BUS_ARB_EN
   localparam int A = 1;
`else
   localparam int A = 0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic [7:0] exp_rdata;

   scmp_bus_ctl_if #(.ADDR_W(16)) bif ();

   scmp_bus_ctl #(
      .STROBE_CYC (S),
      .ADDR_W     (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // {ADS_n, RD_n, WR_n, ack, busy, breq, doe, enout, addr, dout, rdata}
   function automatic logic [39:0] snap();
      return {bif.bus_ADS_n, bif.bus_RD_n, bif.bus_WR_n, bif.mc_ack, bif.busy,
              bif.breq, bif.bus_doe, bif.enout, bif.bus_addr, bif.bus_dout,
              bif.mc_rdata};
   endfunction

   // One complete transaction. w = clocks enin stays low after the request
   // (only meaningful with arbitration), h = extra clocks hold is high.
   task automatic run_cycle(input string name, input bit wr, input logic [15:0] addr,
                            input logic [7:0] wd, input logic [7:0] din,
                            input int h, input int w);
      int ads, done;
      bit in_strb, bsy;
      logic [7:0]  rd_prev;
      logic [39:0] want, got;
      ads     = 1 + A + A * w;
      done    = ads + S + h + 1;
      rd_prev = exp_rdata;
      @(negedge clk);
      bif.mc_req   = 1'b1;
      bif.mc_wr    = wr;
      bif.mc_addr  = addr;
      bif.mc_wdata = wd;
      bif.bus_din  = din;
      bif.hold     = 1'b0;
      bif.enin     = (w == 0);
      @(posedge clk);
      #1;
      // inputs are latched at acceptance; scramble them to prove it
      bif.mc_req   = 1'b0;
      bif.mc_wr    = 1'($urandom_range(1));
      bif.mc_addr  = 16'($urandom);
      bif.mc_wdata = 8'($urandom);
      for (int n = 1; n <= done + 1; n++) begin
         @(negedge clk);
         in_strb = (n > ads) && (n <= ads + S + h);
         bsy     = (n <= done);
         want[39] = (n != ads);
         want[38] = !(in_strb && !wr);
         want[37] = !(in_strb && wr);
         want[36] = (n == done);
         want[35] = bsy;
         want[34] = (A == 1) && bsy;
         want[33] = wr && (n >= ads) && bsy;
         want[32] = (A == 1) ? (bif.enin && !bsy && !bif.mc_req) : bif.enin;
         want[31:16] = addr;
         want[15:8]  = wd;
         want[7:0]   = (n >= done && !wr) ? din : rd_prev;
         got = snap();
         n_checks++;
         if (got !== want) begin
            n_errors++;
            $display("FAIL %s clk %0d: got %h required %h", name, n, got, want);
         end
         // inputs for the coming edge n
         bif.enin = (n < ads) ? (n > w) : 1'($urandom_range(1));
         bif.hold = (n >= ads + S) && (n < ads + S + h);
      end
      bif.hold = 1'b0;
      bif.enin = 1'b1;
      if (!wr) exp_rdata = din;
   endtask

   task automatic test_reset();
      logic [39:0] want;
      want = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};
      n_checks++;
      if (snap() !== want) begin
         n_errors++;
         $display("FAIL reset_state: got %h required %h", snap(), want);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (snap() !== want) begin
         n_errors++;
         $display("FAIL post_reset_idle: got %h required %h", snap(), want);
      end
   endtask

   task automatic test_read();
      run_cycle("read", 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 0);
   endtask

   task automatic test_write();
      run_cycle("write", 1'b1, 16'h0F00, 8'h3C, 8'h00, 0, 0);
   endtask

   task automatic test_enin_wait();
      run_cycle("enin_wait", 1'b0, 16'h5A5A, 8'h11, 8'h7E, 0, 10);
   endtask

   task automatic test_hold();
      run_cycle("hold", 1'b0, 16'hBEEF, 8'h22, 8'hC3, 3, 0);
   endtask

   task automatic test_reset_mid();
      logic [39:0] want;
      logic [15:0] a;
      a = 16'($urandom);
      @(negedge clk);
      bif.mc_req  = 1'b1;
      bif.mc_wr   = 1'b0;
      bif.mc_addr = a;
      bif.bus_din = 8'h99;
      bif.enin    = 1'b1;
      bif.hold    = 1'b0;
      @(posedge clk);
      #1;
      bif.mc_req = 1'b0;
      for (int n = 1; n <= A + 2; n++) @(negedge clk);
      n_checks++;
      if (bif.bus_RD_n !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid_in_strobe: got RD_n=%b required 0", bif.bus_RD_n);
      end
      #2;
      rst_n = 1'b0;
      #1;
      want = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};
      n_checks++;
      if (snap() !== want) begin
         n_errors++;
         $display("FAIL rst_mid_async: got %h required %h", snap(), want);
      end
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bif.mc_ack, bif.busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid_no_ack: got ack,busy=%b required 00", {bif.mc_ack, bif.busy});
         end
      end
      rst_n     = 1'b1;
      exp_rdata = 8'h00;
      run_cycle("after_rst", 1'b0, 16'h4321, 8'h00, 8'h5C, 0, 0);
   endtask

   task automatic test_back_to_back();
      int P, done, ads, acks;
      logic [15:0] addrs [3];
      logic [7:0]  din;
      logic [2:0]  want3;
      P    = S + 3 + A;
      done = P - 1;
      ads  = 1 + A;
      acks = 0;
      din  = 8'($urandom);
      @(negedge clk);
      addrs[0]     = 16'($urandom);
      bif.mc_req   = 1'b1;
      bif.mc_wr    = 1'b0;
      bif.mc_addr  = addrs[0];
      bif.bus_din  = din;
      bif.enin     = 1'b1;
      bif.hold     = 1'b0;
      for (int n = 1; n <= 3 * P; n++) begin
         @(negedge clk);
         want3 = {(n % P == done), (A == 1) && (n % P != 0), (n % P != 0)};
         n_checks++;
         if ({bif.mc_ack, bif.breq, bif.busy} !== want3) begin
            n_errors++;
            $display("FAIL b2b clk %0d: got ack,breq,busy=%b required %b", n,
                     {bif.mc_ack, bif.breq, bif.busy}, want3);
         end
         if (bif.mc_ack === 1'b1) acks++;
         if (n % P == ads) begin
            n_checks++;
            if ({bif.bus_ADS_n, bif.bus_addr} !== {1'b0, addrs[n / P]}) begin
               n_errors++;
               $display("FAIL b2b_ads clk %0d: got %h required %h", n,
                        {bif.bus_ADS_n, bif.bus_addr}, {1'b0, addrs[n / P]});
            end
         end
         if (n % P == 0) begin
            if (n == 3 * P) begin
               bif.mc_req = 1'b0;
            end else begin
               addrs[n / P] = 16'($urandom);
               bif.mc_addr  = addrs[n / P];
            end
         end
      end
      n_checks++;
      if (acks != 3 || bif.mc_rdata !== din) begin
         n_errors++;
         $display("FAIL b2b_total: got acks=%0d rdata=%h required 3 and %h", acks, bif.mc_rdata, din);
      end
      exp_rdata = din;
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         run_cycle("random", 1'($urandom_range(1)), 16'($urandom), 8'($urandom),
                   8'($urandom), int'($urandom_range(3)), int'($urandom_range(4)));
      end
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      exp_rdata    = 8'h00;
      rst_n        = 1'b0;
      bif.mc_req   = 1'b0;
      bif.mc_wr    = 1'b0;
      bif.mc_addr  = 16'h0000;
      bif.mc_wdata = 8'h00;
      bif.enin     = 1'b1;
      bif.hold     = 1'b0;
      bif.bus_din  = 8'h00;
      #12;
      test_reset();
      test_read();
      test_write();
      test_enin_wait();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
